// File: rtl/seq_chunk_adder.sv
// Sequential N-bit adder/subtractor: processes W bits per clock, chaining the
// carry through a register, with a start/done handshake.
module seq_chunk_adder #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sub,
  input  logic [N-1:0] in1,
  input  logic [N-1:0] in2,
  input  logic         Cin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] Sum,
  output logic         Cout,
  output logic         ovf,
  output logic         state_dbg
);

  localparam int C  = N / W;
  localparam int IW = (C > 1) ? $clog2(C) : 1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // Handshake: start is sampled only in IDLE; done is a one-cycle pulse in the
  // cycle after the final chunk edge, and start in that cycle is accepted.
  state_t        state, state_nx;
  logic [N-1:0]  a_q, b_q, acc, sum_full;
  logic          carry;
  logic [IW-1:0] idx;
  logic [W-1:0]  a_chunk, b_chunk, s_chunk;
  logic          c_chunk;
  logic          last;

  always_comb begin
    a_chunk  = a_q[idx*W +: W];
    b_chunk  = b_q[idx*W +: W];
    {c_chunk, s_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk} + {{W{1'b0}}, carry};
    last     = (idx == IW'(C - 1));
    // Accumulator with the current chunk merged in; this is the final result on the last edge.
    sum_full = acc;
    sum_full[idx*W +: W] = s_chunk;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state == RUN);
    state_dbg = state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      Sum   <= '0;
      Cout  <= 1'b0;
      ovf   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // Subtraction is A + ~B + 1, so only the effective B and carry are kept.
            a_q   <= in1;
            b_q   <= sub ? ~in2 : in2;
            carry <= sub ? 1'b1 : Cin;
            acc   <= '0;
            idx   <= '0;
          end
        end
        RUN: begin
          acc   <= sum_full;
          carry <= c_chunk;
          idx   <= last ? '0 : idx + 1'b1;
          if (last) begin
            Sum  <= sum_full;
            Cout <= c_chunk;
            ovf  <= (a_q[N-1] == b_q[N-1]) && (sum_full[N-1] != a_q[N-1]);
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
